// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and types for the 8x8 multiplier.
//   MULT_W    - operand width (8)
//   PROD_W    - full product width (16)
//   operand_t - one operand or the truncated result
//   product_t - full-width product
package mult_pkg;

  localparam int MULT_W = 8;
  localparam int PROD_W = 16;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/multiplier_8x8_if.sv
// multiplier_8x8_if: operand/result bus between the ALU and the multiplier.
//   DATA1    - multiplicand (ALU -> multiplier)
//   DATA2    - multiplier   (ALU -> multiplier)
//   RESULT   - registered low byte of DATA1 * DATA2
//   OVERFLOW - registered |product[15:8]; present only when
//              MULTIPLIER_OVERFLOW_EN is defined
// Modports: master = ALU side, slave = multiplier side.
interface multiplier_8x8_if;
  import mult_pkg::*;

  operand_t DATA1;
  operand_t DATA2;
  operand_t RESULT;
`ifdef MULTIPLIER_OVERFLOW_EN
  logic     OVERFLOW;

  modport master (output DATA1, output DATA2, input RESULT, input OVERFLOW);
  modport slave  (input DATA1, input DATA2, output RESULT, output OVERFLOW);
`else
  modport master (output DATA1, output DATA2, input RESULT);
  modport slave  (input DATA1, input DATA2, output RESULT);
`endif

endinterface

// File: rtl/mult_full_adder.sv
// mult_full_adder: 1-bit full adder cell of the multiplier array.
//   a, b, cin - addend bits and carry in
//   sum, cout - sum bit and carry out
module mult_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/multiplier_8x8.sv
// multiplier_8x8: registered 8x8 shift-and-add array multiplier, low byte out.
//   CLK      - system clock, rising edge
//   RESET    - asynchronous, active-high reset; clears all outputs
//   bus      - multiplier_8x8_if slave: DATA1/DATA2 in, RESULT (and
//              OVERFLOW) out, registered with one cycle of latency
// Build option: MULTIPLIER_OVERFLOW_EN extends the array to the full 16-bit
// product and adds the registered OVERFLOW output (product[15:8] != 0).
// Without it only the low-byte triangle of adder cells is built and carries
// out of bit 7 are dropped; RESULT is the same in both builds.
module multiplier_8x8
  import mult_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  multiplier_8x8_if.slave       bus
);

  // Row r adds partial product pp[r] (DATA1 gated by DATA2[r], shifted by r)
  // into the running sum of rows 0..r-1. Each row ripples its own carry.
  // Bits below r are already final and pass straight through.
  for (genvar r = 0; r < MULT_W; r++) begin : g_row
`ifdef MULTIPLIER_OVERFLOW_EN
    // Row r's sum spans bits [r+8:0]; row 0 carries a constant-zero top bit
    // so every row reads the whole of the previous one.
    localparam int W     = MULT_W + r + 1;
    localparam int N_COL = MULT_W;
`else
    localparam int W     = MULT_W;
    localparam int N_COL = MULT_W - r;
`endif

    logic [W-1:0] acc;

    if (r == 0) begin : g_pp0
      assign acc = W'(bus.DATA1 & {MULT_W{bus.DATA2[0]}});
    end else begin : g_add
      for (genvar c = 0; c < N_COL; c++) begin : g_col
        logic cin;
        logic sum;
        logic cout;

        if (c == 0) begin : g_c0
          assign cin = 1'b0;
        end else begin : g_cn
          assign cin = g_col[c-1].cout;
        end

        // Partial-product bit formed at the cell that consumes it.
        mult_full_adder u_fa (
          .a    (g_row[r-1].acc[r+c]),
          .b    (bus.DATA1[c] & bus.DATA2[r]),
          .cin  (cin),
          .sum  (sum),
          .cout (cout)
        );

        assign acc[r+c] = sum;
      end

      assign acc[r-1:0] = g_row[r-1].acc[r-1:0];

`ifdef MULTIPLIER_OVERFLOW_EN
      assign acc[W-1] = g_col[N_COL-1].cout;
`else
      // Carry out of bit 7 has no home in the truncated build.
      logic carry_unused;
      assign carry_unused = g_col[N_COL-1].cout;
`endif
    end
  end

  operand_t result_q;

`ifdef MULTIPLIER_OVERFLOW_EN
  product_t product;
  logic     overflow_q;

  assign product = g_row[MULT_W-1].acc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= product[MULT_W-1:0];
      overflow_q <= |product[PROD_W-1:MULT_W];
    end
  end

  assign bus.OVERFLOW = overflow_q;
`else
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_q <= '0;
    end else begin
      result_q <= g_row[MULT_W-1].acc;
    end
  end
`endif

  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_multiplier_8x8.sv
// tb_multiplier_8x8: self-checking bench for multiplier_8x8.
// Covers reset (async clear, mid-stream reset), a directed vector table,
// back-to-back operands, random operands and an exhaustive operand sweep.
// OVERFLOW is checked only when MULTIPLIER_OVERFLOW_EN is defined.
module tb_multiplier_8x8;
  import mult_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  multiplier_8x8_if bus ();

  multiplier_8x8 dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  vec_t table_v[9];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: RESULT got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef MULTIPLIER_OVERFLOW_EN
    vectors++;
    if (bus.OVERFLOW !== exp) begin
      miscompares++;
      $display("FAIL %s: OVERFLOW got %b expected %b", name, bus.OVERFLOW, exp);
    end
`else
    if (exp === 1'bx) $display("note: %s", name);
`endif
  endtask

  // Drive operands away from the edge, let one rising edge pass, sample after it.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    bus.DATA1 = a;
    bus.DATA2 = b;
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain integer product.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  initial begin
    logic [15:0] p;
    logic [7:0]  ra, rb;

    table_v[0] = '{8'h03, 8'h05, 8'h0F, 1'b0};
    table_v[1] = '{8'h00, 8'hAB, 8'h00, 1'b0};
    table_v[2] = '{8'h01, 8'hAB, 8'hAB, 1'b0};
    table_v[3] = '{8'h10, 8'h10, 8'h00, 1'b1};
    table_v[4] = '{8'hFF, 8'hFF, 8'h01, 1'b1};
    table_v[5] = '{8'hFD, 8'h04, 8'hF4, 1'b1};
    table_v[6] = '{8'h02, 8'h03, 8'h06, 1'b0};
    table_v[7] = '{8'h0C, 8'h0A, 8'h78, 1'b0};
    table_v[8] = '{8'h80, 8'h02, 8'h00, 1'b1};

    // Reset asserted with operands present: outputs zero before any edge.
    RESET     = 1'b1;
    bus.DATA1 = 8'h07;
    bus.DATA2 = 8'h09;
    #2;
    check8("reset_initial", bus.RESULT, 8'h00);
    check_ovf("reset_initial", 1'b0);
    @(posedge CLK);
    #1;
    check8("reset_held_edge", bus.RESULT, 8'h00);
    RESET = 1'b0;
    apply(8'h07, 8'h09);
    check8("first_after_reset", bus.RESULT, 8'h3F);
    check_ovf("first_after_reset", 1'b0);

    // Directed table, applied back to back.
    foreach (table_v[i]) begin
      apply(table_v[i].a, table_v[i].b);
      check8($sformatf("table[%0d]", i), bus.RESULT, table_v[i].exp_res);
      check_ovf($sformatf("table[%0d]", i), table_v[i].exp_ovf);
    end

    // Mid-stream reset: output clears asynchronously, pending product lost.
    apply(8'hFF, 8'h7F);
    check8("pre_midreset", bus.RESULT, 8'h81);
    bus.DATA1 = 8'h11;
    bus.DATA2 = 8'h11;
    #2;
    RESET = 1'b1;
    #1;
    check8("midreset_async", bus.RESULT, 8'h00);
    check_ovf("midreset_async", 1'b0);
    @(posedge CLK);
    #1;
    check8("midreset_held", bus.RESULT, 8'h00);
    #2;
    RESET = 1'b0;
    apply(8'h11, 8'h11);
    check8("midreset_release", bus.RESULT, 8'h21);
    check_ovf("midreset_release", 1'b1);

    // Random operands against the reference product.
    for (int n = 0; n < 2000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      p  = ref_prod(ra, rb);
      apply(ra, rb);
      check8("random", bus.RESULT, p[7:0]);
      check_ovf("random", |p[15:8]);
    end

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ra = 8'(a);
        rb = 8'(b);
        p  = ref_prod(ra, rb);
        apply(ra, rb);
        check8("sweep", bus.RESULT, p[7:0]);
        check_ovf("sweep", |p[15:8]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
